// File: rtl/renode_pkg.sv
// Types shared between the Renode memory mux and the Renode bus bridge.
package renode_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_WORD  = 2'd1,
        SIZE_DWORD = 2'd2,
        SIZE_QWORD = 2'd3
    } access_size_e;

endpackage

// File: rtl/renode_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i wins; reports the
// one-hot grant, its index and the pointer to use after this grant.
module renode_rr_arbiter #(
    parameter  int NumPorts = 2,
    localparam int PtrW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [PtrW-1:0]     ptr_i,
    output logic                any_o,
    output logic [NumPorts-1:0] gnt_o,
    output logic [PtrW-1:0]     gnt_idx_o,
    output logic [PtrW-1:0]     next_ptr_o
);

    localparam int SumW = PtrW + 1;

    logic [NumPorts-1:0] req_rot;
    logic [PtrW-1:0]     offs;
    logic [SumW-1:0]     win_sum;
    logic [SumW-1:0]     nxt_sum;
    logic                found;

    always_comb begin
        // Rotate so that bit 0 is the port the pointer currently favours.
        req_rot = NumPorts'({req_i, req_i} >> ptr_i);
        found   = 1'b0;
        offs    = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                offs  = PtrW'(i);
            end
        end
        win_sum = SumW'(ptr_i) + SumW'(offs);
        if (win_sum >= SumW'(NumPorts)) win_sum = win_sum - SumW'(NumPorts);
        nxt_sum = win_sum + SumW'(1);
        if (nxt_sum >= SumW'(NumPorts)) nxt_sum = '0;
        any_o      = found;
        gnt_idx_o  = PtrW'(win_sum);
        next_ptr_o = PtrW'(nxt_sum);
        gnt_o      = found ? (NumPorts'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/renode_mem_mux.sv
// N-to-1 memory request mux for the Renode bridge: arbitrates requesters, splits
// byte-enable patterns into legal beats, merges beat responses back to the origin.
module renode_mem_mux
    import renode_pkg::*;
#(
    parameter  int NumPorts  = 2,
    parameter  int AddrWidth = 64,
    parameter  int DataWidth = 64,
    parameter  int IdWidth   = 8,
    localparam int NB        = DataWidth / 8,
    localparam int LaneW     = $clog2(NB),
    localparam int PtrW      = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 up_req_valid_i,
    output logic [NumPorts-1:0]                 up_req_ready_o,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  up_req_addr_i,
    input  logic [NumPorts-1:0]                 up_req_we_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  up_req_wdata_i,
    input  logic [NumPorts-1:0][NB-1:0]         up_req_be_i,
    input  logic [NumPorts-1:0][IdWidth-1:0]    up_req_id_i,
    output logic [NumPorts-1:0]                 up_rsp_valid_o,
    input  logic [NumPorts-1:0]                 up_rsp_ready_i,
    output logic [DataWidth-1:0]                up_rsp_rdata_o,
    output logic                                up_rsp_err_o,
    output logic [IdWidth-1:0]                  up_rsp_id_o,
    output logic                                dn_req_valid_o,
    input  logic                                dn_req_ready_i,
    output logic [AddrWidth-1:0]                dn_req_addr_o,
    output logic                                dn_req_we_o,
    output logic [DataWidth-1:0]                dn_req_wdata_o,
    output logic [1:0]                          dn_req_size_o,
    input  logic                                dn_rsp_valid_i,
    input  logic [DataWidth-1:0]                dn_rsp_rdata_i,
    input  logic                                dn_rsp_err_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    typedef struct packed {
        logic             single;
        access_size_e     size;
        logic [LaneW-1:0] lane;
    } plan_t;

    // A naturally aligned power-of-two run maps to one beat; anything else is split per byte.
    function automatic plan_t plan_beats(input logic [NB-1:0] be);
        plan_t         p;
        int            first;
        int            cnt;
        logic [NB-1:0] run;
        p     = '{single: 1'b0, size: SIZE_BYTE, lane: '0};
        first = 0;
        cnt   = 0;
        for (int i = NB - 1; i >= 0; i--) if (be[i]) first = i;
        for (int i = 0; i < NB; i++) if (be[i]) cnt++;
        run = NB'((1 << cnt) - 1) << first;
        if (cnt != 0 && be == run && (first % cnt) == 0) begin
            case (cnt)
                1:       begin p.single = 1'b1; p.size = SIZE_BYTE;  end
                2:       begin p.single = 1'b1; p.size = SIZE_WORD;  end
                4:       begin p.single = 1'b1; p.size = SIZE_DWORD; end
                8:       begin p.single = 1'b1; p.size = SIZE_QWORD; end
                default: ;
            endcase
        end
        p.lane = LaneW'(first);
        return p;
    endfunction

    function automatic logic [NB-1:0] lowest_lane(input logic [NB-1:0] m);
        return m & (~m + NB'(1));
    endfunction

    function automatic logic [LaneW-1:0] lane_of(input logic [NB-1:0] onehot);
        logic [LaneW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NB; i++) if (onehot[i]) idx = LaneW'(i);
        return idx;
    endfunction

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        rr_ptr_q, port_q;
    logic [AddrWidth-1:0]   addr_q;
    logic                   we_q, single_q, err_q;
    logic [DataWidth-1:0]   wdata_q, acc_q;
    logic [IdWidth-1:0]     id_q;
    logic [NB-1:0]          rem_q;
    access_size_e           size_q;
    logic [LaneW-1:0]       lane_q;

    logic                   arb_any;
    logic [NumPorts-1:0]    arb_gnt;
    logic [PtrW-1:0]        arb_idx, arb_next;
    logic [NB-1:0]          gnt_be;
    plan_t                  gnt_plan;
    logic [NB-1:0]          beat_mask, rem_after;
    logic [LaneW-1:0]       beat_lane;
    access_size_e           beat_size;
    logic                   accept, beat_done;
    logic                   lane_bits_unused;

    renode_rr_arbiter #(.NumPorts(NumPorts)) u_arb (
        .req_i      (up_req_valid_i),
        .ptr_i      (rr_ptr_q),
        .any_o      (arb_any),
        .gnt_o      (arb_gnt),
        .gnt_idx_o  (arb_idx),
        .next_ptr_o (arb_next)
    );

    assign gnt_be    = up_req_be_i[arb_idx];
    assign gnt_plan  = plan_beats(gnt_be);
    assign accept    = (state_q == IDLE) && arb_any;
    assign beat_done = (state_q == WAIT) && dn_rsp_valid_i;

    // Remaining lanes drive the current beat; a split beat always takes the lowest one.
    assign beat_mask        = single_q ? rem_q : lowest_lane(rem_q);
    assign beat_lane        = single_q ? lane_q : lane_of(beat_mask);
    assign beat_size        = single_q ? size_q : SIZE_BYTE;
    assign rem_after        = rem_q & ~beat_mask;
    assign lane_bits_unused = ^addr_q[LaneW-1:0];

    always_comb begin
        state_d        = state_q;
        up_req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    up_req_ready_o = arb_gnt & {NumPorts{rst_ni}};
                    state_d        = (gnt_be == '0) ? RESP : ISSUE;
                end
            end
            ISSUE:   if (dn_req_ready_i) state_d = WAIT;
            WAIT:    if (dn_rsp_valid_i) state_d = (rem_after == '0) ? RESP : ISSUE;
            RESP:    if (up_rsp_ready_i[port_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            port_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            id_q     <= '0;
            rem_q    <= '0;
            single_q <= 1'b0;
            size_q   <= SIZE_BYTE;
            lane_q   <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            rr_ptr_q <= arb_next;
            port_q   <= arb_idx;
            addr_q   <= up_req_addr_i[arb_idx];
            we_q     <= up_req_we_i[arb_idx];
            wdata_q  <= up_req_wdata_i[arb_idx];
            id_q     <= up_req_id_i[arb_idx];
            rem_q    <= gnt_be;
            single_q <= gnt_plan.single;
            size_q   <= gnt_plan.size;
            lane_q   <= gnt_plan.lane;
            acc_q    <= '0;
            err_q    <= (gnt_be == '0);
        end else if (beat_done) begin
            rem_q <= rem_after;
            err_q <= err_q | dn_rsp_err_i;
            if (!we_q) begin
                for (int i = 0; i < NB; i++) begin
                    if (beat_mask[i]) acc_q[i*8 +: 8] <= dn_rsp_rdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign dn_req_valid_o = (state_q == ISSUE);
    assign dn_req_addr_o  = dn_req_valid_o ? {addr_q[AddrWidth-1:LaneW], beat_lane} : '0;
    assign dn_req_we_o    = dn_req_valid_o & we_q;
    assign dn_req_wdata_o = dn_req_valid_o ? wdata_q : '0;
    assign dn_req_size_o  = dn_req_valid_o ? beat_size : SIZE_BYTE;

    assign up_rsp_valid_o = (state_q == RESP) ? (NumPorts'(1) << port_q) : '0;
    assign up_rsp_rdata_o = (state_q == RESP && !we_q) ? acc_q : '0;
    assign up_rsp_err_o   = (state_q == RESP) & err_q;
    assign up_rsp_id_o    = (state_q == RESP) ? id_q : '0;

    dn_rsp_only_in_wait: assert property (
        @(posedge clk_i) disable iff (!rst_ni) dn_rsp_valid_i |-> (state_q == WAIT)
    );

endmodule

// File: tb/tb_renode_mem_mux.sv
// Directed scoreboard bench for renode_mem_mux (2 ports, 64-bit data).
module tb_renode_mem_mux;

    localparam int NP = 2;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  size;
        logic        we;
        logic [63:0] wdata;
    } beat_t;

    typedef struct {
        int          port;
        logic [63:0] rdata;
        logic        err;
        logic [7:0]  id;
    } rsp_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NP-1:0]        up_req_valid_i, up_req_ready_o;
    logic [NP-1:0][63:0]  up_req_addr_i;
    logic [NP-1:0]        up_req_we_i;
    logic [NP-1:0][63:0]  up_req_wdata_i;
    logic [NP-1:0][7:0]   up_req_be_i;
    logic [NP-1:0][7:0]   up_req_id_i;
    logic [NP-1:0]        up_rsp_valid_o, up_rsp_ready_i;
    logic [63:0]          up_rsp_rdata_o;
    logic                 up_rsp_err_o;
    logic [7:0]           up_rsp_id_o;
    logic                 dn_req_valid_o, dn_req_ready_i;
    logic [63:0]          dn_req_addr_o;
    logic                 dn_req_we_o;
    logic [63:0]          dn_req_wdata_o;
    logic [1:0]           dn_req_size_o;
    logic                 dn_rsp_valid_i;
    logic [63:0]          dn_rsp_rdata_i;
    logic                 dn_rsp_err_i;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    beat_t beat_q[$];
    rsp_t  rsp_q[$];

    renode_mem_mux #(.NumPorts(NP), .AddrWidth(64), .DataWidth(64), .IdWidth(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .up_req_valid_i (up_req_valid_i),
        .up_req_ready_o (up_req_ready_o),
        .up_req_addr_i  (up_req_addr_i),
        .up_req_we_i    (up_req_we_i),
        .up_req_wdata_i (up_req_wdata_i),
        .up_req_be_i    (up_req_be_i),
        .up_req_id_i    (up_req_id_i),
        .up_rsp_valid_o (up_rsp_valid_o),
        .up_rsp_ready_i (up_rsp_ready_i),
        .up_rsp_rdata_o (up_rsp_rdata_o),
        .up_rsp_err_o   (up_rsp_err_o),
        .up_rsp_id_o    (up_rsp_id_o),
        .dn_req_valid_o (dn_req_valid_o),
        .dn_req_ready_i (dn_req_ready_i),
        .dn_req_addr_o  (dn_req_addr_o),
        .dn_req_we_o    (dn_req_we_o),
        .dn_req_wdata_o (dn_req_wdata_o),
        .dn_req_size_o  (dn_req_size_o),
        .dn_rsp_valid_i (dn_rsp_valid_i),
        .dn_rsp_rdata_i (dn_rsp_rdata_i),
        .dn_rsp_err_i   (dn_rsp_err_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout, expected DUT event", tag);
    endtask

    task automatic set_req(input int p, input logic [63:0] addr, input logic we,
                           input logic [63:0] wdata, input logic [7:0] be, input logic [7:0] id);
        up_req_addr_i[p]  = addr;
        up_req_we_i[p]    = we;
        up_req_wdata_i[p] = wdata;
        up_req_be_i[p]    = be;
        up_req_id_i[p]    = id;
        up_req_valid_i[p] = 1'b1;
    endtask

    task automatic push_beat(input logic [63:0] addr, input logic [1:0] size,
                             input logic we, input logic [63:0] wdata);
        beat_t b;
        b.addr = addr; b.size = size; b.we = we; b.wdata = wdata;
        beat_q.push_back(b);
    endtask

    task automatic push_rsp(input int port, input logic [63:0] rdata, input logic err,
                            input logic [7:0] id);
        rsp_t r;
        r.port = port; r.rdata = rdata; r.err = err; r.id = id;
        rsp_q.push_back(r);
    endtask

    // Called in the first half of a cycle; returns just after the accepting edge.
    task automatic wait_accept(input int p, input bit keep, output int acc_cyc);
        bit done;
        done    = 1'b0;
        acc_cyc = cyc;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk_i);
            if (up_req_ready_o != '0) begin
                check("grant", 64'(up_req_ready_o), 64'(1) << p);
                acc_cyc = cyc;
                done    = 1'b1;
                @(posedge clk_i); #1;
                if (!keep) up_req_valid_i[p] = 1'b0;
            end
        end
        if (!done) begin
            timeout("grant");
            up_req_valid_i[p] = 1'b0;
        end
    endtask

    task automatic serve_beat(input logic [63:0] rdata, input logic err, input int stall);
        bit    found;
        beat_t exp;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (dn_req_valid_o) found = 1'b1;
        end
        if (!found) begin
            timeout("beat");
            return;
        end
        if (beat_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL beat_unexpected: observed beat at %h, expected none", dn_req_addr_o);
            exp.addr = dn_req_addr_o; exp.size = 2'd0; exp.we = 1'b0; exp.wdata = 64'd0;
        end else begin
            exp = beat_q.pop_front();
            check("beat_addr", dn_req_addr_o, exp.addr);
            check("beat_size", 64'(dn_req_size_o), 64'(exp.size));
            check("beat_we", 64'(dn_req_we_o), 64'(exp.we));
            if (exp.we) check("beat_wdata", dn_req_wdata_o, exp.wdata);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk_i);
            check("beat_hold_valid", 64'(dn_req_valid_o), 64'd1);
            check("beat_hold_addr", dn_req_addr_o, exp.addr);
        end
        dn_req_ready_i = 1'b1;
        @(posedge clk_i); #1;
        dn_req_ready_i = 1'b0;
        dn_rsp_valid_i = 1'b1;
        dn_rsp_rdata_i = rdata;
        dn_rsp_err_i   = err;
        @(posedge clk_i); #1;
        dn_rsp_valid_i = 1'b0;
        dn_rsp_rdata_i = 64'd0;
        dn_rsp_err_i   = 1'b0;
    endtask

    task automatic collect_rsp(output int rsp_cyc);
        bit   found;
        rsp_t exp;
        found   = 1'b0;
        rsp_cyc = cyc;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (up_rsp_valid_o != '0) found = 1'b1;
        end
        if (!found) begin
            timeout("response");
            return;
        end
        rsp_cyc = cyc;
        if (rsp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL rsp_unexpected: observed valid %b, expected none", up_rsp_valid_o);
            exp.port = 0;
        end else begin
            exp = rsp_q.pop_front();
            check("rsp_port", 64'(up_rsp_valid_o), 64'(1) << exp.port);
            check("rsp_rdata", up_rsp_rdata_o, exp.rdata);
            check("rsp_err", 64'(up_rsp_err_o), 64'(exp.err));
            check("rsp_id", 64'(up_rsp_id_o), 64'(exp.id));
            check("rsp_no_grant", 64'(up_req_ready_o), 64'd0);
            check("rsp_dn_idle", 64'(dn_req_valid_o), 64'd0);
        end
        up_rsp_ready_i[exp.port] = 1'b1;
        @(posedge clk_i); #1;
        up_rsp_ready_i = '0;
    endtask

    initial begin
        int          acc;
        int          rc;
        int          p;
        logic [63:0] d;
        bit          found;
        beat_t       b;

        rst_ni         = 1'b0;
        up_req_valid_i = '0;
        up_req_addr_i  = '0;
        up_req_we_i    = '0;
        up_req_wdata_i = '0;
        up_req_be_i    = '0;
        up_req_id_i    = '0;
        up_rsp_ready_i = '0;
        dn_req_ready_i = 1'b0;
        dn_rsp_valid_i = 1'b0;
        dn_rsp_rdata_i = 64'd0;
        dn_rsp_err_i   = 1'b0;

        repeat (2) @(negedge clk_i);
        check("rst_dn_valid", 64'(dn_req_valid_o), 64'd0);
        check("rst_rsp_valid", 64'(up_rsp_valid_o), 64'd0);
        check("rst_req_ready", 64'(up_req_ready_o), 64'd0);
        check("rst_dn_addr", dn_req_addr_o, 64'd0);
        check("rst_rsp_err", 64'(up_rsp_err_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Single full-width read on port 0, zero-wait downstream.
        set_req(0, 64'h1000, 1'b0, 64'd0, 8'hFF, 8'h11);
        push_beat(64'h1000, 2'd3, 1'b0, 64'd0);
        push_rsp(0, 64'h1122334455667788, 1'b0, 8'h11);
        wait_accept(0, 1'b0, acc);
        serve_beat(64'h1122334455667788, 1'b0, 0);
        collect_rsp(rc);
        check("t1_latency", 64'(rc - acc), 64'd3);

        // Aligned Word write on port 1, downstream stalls two cycles.
        set_req(1, 64'h2000, 1'b1, 64'hDEADBEEFCAFEF00D, 8'h0C, 8'h22);
        push_beat(64'h2002, 2'd1, 1'b1, 64'hDEADBEEFCAFEF00D);
        push_rsp(1, 64'd0, 1'b0, 8'h22);
        wait_accept(1, 1'b0, acc);
        serve_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2);
        collect_rsp(rc);

        // Both ports hold requests; port 1 was granted last so port 0 goes first.
        set_req(0, 64'h5000, 1'b0, 64'd0, 8'hFF, 8'hA0);
        set_req(1, 64'h4007, 1'b0, 64'd0, 8'hFF, 8'hB1);
        for (int k = 0; k < 4; k++) begin
            p = k % 2;
            d = 64'hC0DE_0000_0000_0000 | 64'(k);
            push_beat((p == 0) ? 64'h5000 : 64'h4000, 2'd3, 1'b0, 64'd0);
            push_rsp(p, d, 1'b0, (p == 0) ? 8'hA0 : 8'hB1);
            wait_accept(p, 1'b1, acc);
            serve_beat(d, 1'b0, 0);
            collect_rsp(rc);
        end
        up_req_valid_i = '0;

        // Split read, middle beat errors.
        set_req(0, 64'h3000, 1'b0, 64'd0, 8'h0E, 8'h33);
        push_beat(64'h3001, 2'd0, 1'b0, 64'd0);
        push_beat(64'h3002, 2'd0, 1'b0, 64'd0);
        push_beat(64'h3003, 2'd0, 1'b0, 64'd0);
        push_rsp(0, 64'h0000_0000_3322_1100, 1'b1, 8'h33);
        wait_accept(0, 1'b0, acc);
        serve_beat(64'h1111_1111_1111_1111, 1'b0, 0);
        serve_beat(64'h2222_2222_2222_2222, 1'b1, 0);
        serve_beat(64'h3333_3333_3333_3333, 1'b0, 0);
        collect_rsp(rc);

        // Empty byte-enable: immediate error response, nothing downstream.
        set_req(1, 64'h8000, 1'b0, 64'd0, 8'h00, 8'h44);
        push_rsp(1, 64'd0, 1'b1, 8'h44);
        wait_accept(1, 1'b0, acc);
        collect_rsp(rc);
        check("t5_latency", 64'(rc - acc), 64'd1);

        // Reset while waiting on the first beat of a three-beat split.
        set_req(0, 64'h6000, 1'b0, 64'd0, 8'h0E, 8'h55);
        push_beat(64'h6001, 2'd0, 1'b0, 64'd0);
        wait_accept(0, 1'b0, acc);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (dn_req_valid_o) found = 1'b1;
        end
        if (!found) timeout("t6_beat");
        else begin
            b = beat_q.pop_front();
            check("t6_beat_addr", dn_req_addr_o, b.addr);
        end
        dn_req_ready_i = 1'b1;
        @(posedge clk_i); #1;
        dn_req_ready_i = 1'b0;
        set_req(0, 64'h7000, 1'b0, 64'd0, 8'hFF, 8'h21);
        set_req(1, 64'h7100, 1'b0, 64'd0, 8'hFF, 8'h22);
        rst_ni = 1'b0;
        #1;
        check("mrst_req_ready", 64'(up_req_ready_o), 64'd0);
        check("mrst_dn_valid", 64'(dn_req_valid_o), 64'd0);
        check("mrst_dn_addr", dn_req_addr_o, 64'd0);
        check("mrst_dn_size", 64'(dn_req_size_o), 64'd0);
        check("mrst_dn_we", 64'(dn_req_we_o), 64'd0);
        check("mrst_dn_wdata", dn_req_wdata_o, 64'd0);
        check("mrst_rsp_valid", 64'(up_rsp_valid_o), 64'd0);
        check("mrst_rsp_rdata", up_rsp_rdata_o, 64'd0);
        check("mrst_rsp_err", 64'(up_rsp_err_o), 64'd0);
        check("mrst_rsp_id", 64'(up_rsp_id_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        check("mrst_no_stale_rsp", 64'(up_rsp_valid_o), 64'd0);
        push_beat(64'h7000, 2'd3, 1'b0, 64'd0);
        push_rsp(0, 64'h0123_4567_89AB_CDEF, 1'b0, 8'h21);
        wait_accept(0, 1'b0, acc);
        up_req_valid_i[1] = 1'b0;
        serve_beat(64'h0123_4567_89AB_CDEF, 1'b0, 0);
        collect_rsp(rc);

        check("sb_beats_drained", 64'(beat_q.size()), 64'd0);
        check("sb_rsps_drained", 64'(rsp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
